// File: rtl/ok_host.sv
// Host-side bridge: turns strobed header/data words on okUHU into endpoint write/read strobes.
// Optional read-acknowledge timeout is enabled with `define OKHOST_READ_TIMEOUT_EN.
module ok_host #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic [4:0]   okUH,
    output logic [2:0]   okHU,
    inout  wire  [31:0]  okUHU,
    inout  wire          okAA,
    output logic         okClk,
    output logic [112:0] okHE,
    input  logic [64:0]  okEH
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WDATA   = 3'd1;
    localparam logic [2:0] RD_REQ  = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_OUT  = 3'd4;
    localparam logic [2:0] TURN    = 3'd5;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        rw;
    logic        ack;
    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [7:0]  addr_r;
    logic [16:0] remaining_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        wr_stb_r;
    logic        rd_stb_r;
    logic        last_r;
    logic        ready_r;
    logic        valid_r;
    logic        aa_r;
    logic        err_s;
    logic        timeout_s;
    logic        unused_bits;

    assign clk    = okUH[0];
    assign rst    = okUH[1];
    assign strobe = okUH[2];
    assign rw     = okUH[3];
    assign ack    = okEH[32];

`ifdef OKHOST_READ_TIMEOUT_EN
    logic [31:0] wait_cnt_r;
    logic        err_r;

    assign timeout_s = (state_r == RD_WAIT) && !ack && (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1));
    assign err_s     = err_r;

    // Count cycles spent waiting for the endpoint acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 32'd0;
        end else if (state_r == RD_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
        end else begin
            wait_cnt_r <= 32'd0;
        end
    end

    // Sticky timeout flag, cleared by the next accepted header.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_r == IDLE && strobe) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err_s     = 1'b0;
`endif

    // Next-state decode; outputs are registered from it so they line up with the state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (strobe) begin
                    next_state_s = rw ? WDATA : RD_REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WDATA: begin
                if (strobe && remaining_r == 17'd1) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WDATA;
                end
            end
            RD_REQ:  next_state_s = RD_WAIT;
            RD_WAIT: begin
                if (ack || timeout_s) begin
                    next_state_s = RD_OUT;
                end else begin
                    next_state_s = RD_WAIT;
                end
            end
            RD_OUT: begin
                if (remaining_r == 17'd1) begin
                    next_state_s = TURN;
                end else begin
                    next_state_s = RD_REQ;
                end
            end
            TURN:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= 8'd0;
            remaining_r <= 17'd0;
            wdata_r     <= 32'd0;
            rdata_r     <= 32'd0;
            wr_stb_r    <= 1'b0;
            rd_stb_r    <= 1'b0;
            last_r      <= 1'b0;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            aa_r        <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            ready_r  <= (next_state_s == IDLE) || (next_state_s == WDATA);
            rd_stb_r <= (next_state_s == RD_REQ);
            valid_r  <= (next_state_s == RD_OUT);
            aa_r     <= okEH[64];
            wr_stb_r <= (state_r == WDATA) && strobe;
            last_r   <= (state_r == WDATA) && strobe && (remaining_r == 17'd1);
            case (state_r)
                IDLE: begin
                    if (strobe) begin
                        addr_r      <= okUHU[7:0];
                        remaining_r <= {1'b0, okUHU[23:8]} + 17'd1;
                    end
                end
                WDATA: begin
                    if (strobe) begin
                        wdata_r     <= okUHU;
                        remaining_r <= remaining_r - 17'd1;
                    end
                end
                RD_WAIT: begin
                    if (ack) begin
                        rdata_r <= okEH[31:0];
                    end else if (timeout_s) begin
                        rdata_r <= 32'hFFFF_FFFF;
                    end
                end
                RD_OUT:  remaining_r <= remaining_r - 17'd1;
                default: remaining_r <= remaining_r;
            endcase
        end
    end

    assign okClk = clk;
    assign okHU  = {err_s, valid_r, ready_r};
    assign okHE  = {68'd0, wdata_r, addr_r, last_r, rd_stb_r, wr_stb_r, rst, clk};
    assign okUHU = valid_r ? rdata_r : 32'bz;
    // Open-drain: only ever pull low.
    assign okAA  = aa_r ? 1'b0 : 1'bz;

    assign unused_bits = ^{okUH[4], okEH[63:33], okAA, (TIMEOUT_CYCLES != 0)};

endmodule

// File: tb/tb_ok_host.sv
// Self-checking bench for ok_host: write/read transfers, attention, reset and optional timeout.
module tb_ok_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic        rw = 1'b0;
    logic        host_oe = 1'b0;
    logic [31:0] host_data = 32'd0;
    logic [64:0] eh = 65'd0;
    logic [4:0]  uh;
    logic [2:0]  okHU;
    logic        okClk;
    logic [112:0] okHE;
    wire  [31:0] okUHU;
    wire         okAA;

    int tests = 0;
    int fails = 0;
    logic [40:0] wr_q[$];
    logic [31:0] rd_q[$];

    assign uh    = {1'b0, rw, strobe, rst, clk};
    assign okUHU = host_oe ? host_data : 32'bz;
    pullup (okAA);

    ok_host #(.TIMEOUT_CYCLES(16)) dut (
        .okUH (uh),
        .okHU (okHU),
        .okUHU(okUHU),
        .okAA (okAA),
        .okClk(okClk),
        .okHE (okHE),
        .okEH (eh)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [7:0] addr, input logic [15:0] cnt, input logic is_wr);
        strobe = 1'b1;
        rw = is_wr;
        host_oe = 1'b1;
        host_data = {8'hA5, cnt, addr};
        cyc();
        strobe = 1'b0;
        host_oe = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        tests++;
        if (okHU !== 3'b000) begin fails++; $display("FAIL reset_okHU got %b want 000", okHU); end
        tests++;
        if (okHE[4:2] !== 3'b000) begin fails++; $display("FAIL reset_okHE got %b want 000", okHE[4:2]); end
        tests++;
        if (okAA !== 1'b1) begin fails++; $display("FAIL reset_okAA got %b want released", okAA); end
        tests++;
        if (okHE[1] !== 1'b1 || okClk !== clk) begin fails++; $display("FAIL reset_passthru got rst=%b clk=%b want 1/%b", okHE[1], okClk, clk); end
        rst = 1'b0;
        cyc();
        tests++;
        if (okHU[0] !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", okHU[0]); end
    endtask

    task automatic test_write();
        int pulses = 0;
        send_header(8'h42, 16'd1, 1'b1);
        tests++;
        if (okHU[0] !== 1'b1) begin fails++; $display("FAIL wr_ready got %b want 1", okHU[0]); end
        for (int i = 0; i < 5; i++) begin
            strobe = (i == 0) || (i == 2);
            host_oe = strobe;
            host_data = (i == 0) ? 32'h1111_1111 : 32'h2222_2222;
            if (strobe) wr_q.push_back({8'h42, host_data, (i == 2)});
            cyc();
            if (okHE[2]) begin
                pulses++;
                tests++;
                if (wr_q.size() == 0) begin
                    fails++; $display("FAIL wr_unexpected got strobe data %h want none", okHE[44:13]);
                end else begin
                    logic [40:0] e;
                    e = wr_q.pop_front();
                    if ({okHE[12:5], okHE[44:13], okHE[4]} !== e) begin
                        fails++; $display("FAIL wr_word got %h want %h", {okHE[12:5], okHE[44:13], okHE[4]}, e);
                    end
                end
            end
        end
        strobe = 1'b0;
        host_oe = 1'b0;
        tests++;
        if (pulses != 2 || wr_q.size() != 0) begin fails++; $display("FAIL wr_count got %0d want 2", pulses); end
        tests++;
        if (okHU[0] !== 1'b1) begin fails++; $display("FAIL wr_idle got %b want 1", okHU[0]); end
    endtask

    task automatic test_read_single();
        int n = 0;
        send_header(8'h20, 16'd0, 1'b0);
        tests++;
        if (okHE[3] !== 1'b1 || okHU[0] !== 1'b0 || okHE[12:5] !== 8'h20) begin
            fails++; $display("FAIL rd_req got stb=%b rdy=%b addr=%h want 1/0/20", okHE[3], okHU[0], okHE[12:5]);
        end
        cyc();
        tests++;
        if (okHE[3] !== 1'b0) begin fails++; $display("FAIL rd_req_pulse got %b want 0", okHE[3]); end
        cyc();
        eh[31:0] = 32'hCAFE_F00D;
        eh[32] = 1'b1;
        rd_q.push_back(32'hCAFE_F00D);
        cyc();
        eh[32] = 1'b0;
        eh[31:0] = 32'h0;
        while (okHU[1] !== 1'b1 && n < 20) begin cyc(); n++; end
        tests++;
        if (okHU[1] !== 1'b1) begin
            fails++; $display("FAIL rd_valid_timeout got %b want 1", okHU[1]);
        end else if (okUHU !== rd_q[0]) begin
            fails++; $display("FAIL rd_data got %h want %h", okUHU, rd_q[0]);
        end
        void'(rd_q.pop_front());
        cyc();
        tests++;
        if (okHU[1:0] !== 2'b00) begin fails++; $display("FAIL rd_turn got %b want 00", okHU[1:0]); end
        cyc();
        tests++;
        if (okHU[0] !== 1'b1) begin fails++; $display("FAIL rd_idle got %b want 1", okHU[0]); end
    endtask

    task automatic test_back_to_back_read();
        int words = 0;
        int turns = 0;
        logic [31:0] d;
        send_header(8'h55, 16'd2, 1'b0);
        for (int i = 0; i < 40 && turns == 0; i++) begin
            if (okHE[3]) begin
                d = 32'h1000_0000 + $urandom_range(0, 32'hFFFF);
                eh[31:0] = d;
                eh[32] = 1'b1;
                rd_q.push_back(d);
            end
            if (okHU[1]) begin
                eh[32] = 1'b0;
                words++;
                tests++;
                if (rd_q.size() == 0) begin
                    fails++; $display("FAIL b2b_unexpected got %h want none", okUHU);
                end else begin
                    d = rd_q.pop_front();
                    if (okUHU !== d || okHE[12:5] !== 8'h55) begin
                        fails++; $display("FAIL b2b_data got %h@%h want %h@55", okUHU, okHE[12:5], d);
                    end
                end
            end else if (words == 3 && okHU[0] == 1'b1) begin
                turns = 1;
            end
            cyc();
        end
        eh[32] = 1'b0;
        tests++;
        if (words != 3 || turns != 1) begin fails++; $display("FAIL b2b_count got %0d words want 3", words); end
    endtask

`ifdef OKHOST_READ_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        send_header(8'h30, 16'd0, 1'b0);
        while (okHU[1] !== 1'b1 && n < 40) begin cyc(); n++; end
        tests++;
        if (okUHU !== 32'hFFFF_FFFF || okHU[2] !== 1'b1 || n != 17) begin
            fails++; $display("FAIL to_data got %h err=%b after %0d want ffffffff/1 after 17", okUHU, okHU[2], n);
        end
        cyc();
        cyc();
        tests++;
        if (okHU[2] !== 1'b1 || okHU[0] !== 1'b1) begin fails++; $display("FAIL to_sticky got %b want 1x1", okHU); end
        send_header(8'h31, 16'd0, 1'b1);
        tests++;
        if (okHU[2] !== 1'b0) begin fails++; $display("FAIL to_clear got %b want 0", okHU[2]); end
        strobe = 1'b1; host_oe = 1'b1; host_data = 32'h0;
        cyc();
        strobe = 1'b0; host_oe = 1'b0;
        cyc();
    endtask
`else
    task automatic test_timeout();
        tests++;
        if (okHU[2] !== 1'b0) begin fails++; $display("FAIL to_const got %b want 0", okHU[2]); end
    endtask
`endif

    task automatic test_attention();
        eh[64] = 1'b1;
        cyc();
        tests++;
        if (okAA !== 1'b0) begin fails++; $display("FAIL attn_low got %b want 0", okAA); end
        eh[64] = 1'b0;
        cyc();
        tests++;
        if (okAA !== 1'b1) begin fails++; $display("FAIL attn_release got %b want released", okAA); end
    endtask

    task automatic test_reset_mid_write();
        logic [40:0] e;
        send_header(8'h77, 16'd2, 1'b1);
        strobe = 1'b1; host_oe = 1'b1; host_data = 32'h3333_3333;
        cyc();
        tests++;
        if (okHE[2] !== 1'b1 || okHE[44:13] !== 32'h3333_3333) begin
            fails++; $display("FAIL mid_first got %b/%h want 1/33333333", okHE[2], okHE[44:13]);
        end
        rst = 1'b1;
        host_data = 32'h4444_4444;
        cyc();
        rst = 1'b0; strobe = 1'b0; host_oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (okHE[2] !== 1'b0) begin fails++; $display("FAIL mid_no_strobe got %b want 0", okHE[2]); end
            cyc();
        end
        send_header(8'h10, 16'd0, 1'b1);
        tests++;
        if (okHE[2] !== 1'b0) begin fails++; $display("FAIL mid_header_as_data got %b want 0", okHE[2]); end
        strobe = 1'b1; host_oe = 1'b1; host_data = 32'hABCD_0123;
        wr_q.push_back({8'h10, 32'hABCD_0123, 1'b1});
        cyc();
        strobe = 1'b0; host_oe = 1'b0;
        tests++;
        if (okHE[2] !== 1'b1 || wr_q.size() == 0) begin
            fails++; $display("FAIL mid_idle_write got %b want 1", okHE[2]);
        end else begin
            e = wr_q.pop_front();
            if ({okHE[12:5], okHE[44:13], okHE[4]} !== e) begin
                fails++; $display("FAIL mid_idle_word got %h want %h", {okHE[12:5], okHE[44:13], okHE[4]}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_single();
        test_back_to_back_read();
        test_timeout();
        test_attention();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
